if_fetch_queue: RTL

//  Parametrised front-end fetch stage: holds the fetch PC and a one-line I$ buffer, slices up to FETCH_W

---
 rtl/if_fetch_queue_if.sv | 26 ++
 rtl/if_fetch_queue.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/if_fetch_queue_if.sv
// Decode-side dequeue port of the fetch queue: up to FETCH_W in-order entries per cycle.
// The consumer accepts every presented slot when out_ready is high.
interface if_fetch_queue_if #(
  parameter int ADDR_W  = 32,
  parameter int INST_W  = 32,
  parameter int FETCH_W = 2,
  parameter int HIST_W  = 8
);
  logic [FETCH_W-1:0]        out_valid;
  logic [FETCH_W*ADDR_W-1:0] out_pc;
  logic [FETCH_W*INST_W-1:0] out_inst;
  logic [FETCH_W-1:0]        out_pred_taken;
  logic [FETCH_W*ADDR_W-1:0] out_pred_target;
  logic [FETCH_W*HIST_W-1:0] out_pred_hist;
  logic                      out_ready;

  modport master (
    output out_valid, out_pc, out_inst, out_pred_taken, out_pred_target, out_pred_hist,
    input  out_ready
  );

  modport slave (
    input  out_valid, out_pc, out_inst, out_pred_taken, out_pred_target, out_pred_hist,
    output out_ready
  );
endinterface

// File: rtl/if_fetch_queue.sv
// Front-end fetch stage: fetch PC, one-line I$ buffer, predictor-truncated fetch groups
// and a circular instruction queue drained by decode through a ready/valid port.
module if_fetch_queue #(
  parameter int                ADDR_W     = 32,
  parameter int                INST_W     = 32,
  parameter int                LINE_WORDS = 4,
  parameter int                FETCH_W    = 2,
  parameter int                QDEPTH     = 8,
  parameter int                HIST_W     = 8,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           flush,
  input  logic [ADDR_W-1:0]              redirect_pc,
  output logic                           ic_req,
  output logic [ADDR_W-1:0]              ic_paddr,
  input  logic [LINE_WORDS*INST_W-1:0]   ic_rdata_line,
  input  logic                           ic_valid,
  input  logic                           ic_stall,
  output logic                           bp_query_valid,
  output logic [ADDR_W-1:0]              bp_query_pc,
  input  logic [FETCH_W-1:0]             bp_taken_mask,
  input  logic [ADDR_W-1:0]              bp_target,
  input  logic [HIST_W-1:0]              bp_hist,
  if_fetch_queue_if.master               deq,
  output logic [$clog2(QDEPTH+1)-1:0]    q_count
);
  localparam int OFF_W = $clog2(LINE_WORDS*4);
  localparam int TAG_W = ADDR_W - OFF_W;
  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = $clog2(QDEPTH+1);
  localparam int LINE_W = LINE_WORDS*INST_W;

  typedef struct packed {
    logic [ADDR_W-1:0] pc;
    logic [INST_W-1:0] inst;
    logic              taken;
    logic [ADDR_W-1:0] target;
    logic [HIST_W-1:0] hist;
  } entry_t;

  logic [ADDR_W-1:0] pc_q, pc_d;
  logic              buf_valid_q, buf_valid_d;
  logic [TAG_W-1:0]  buf_tag_q, buf_tag_d;
  logic [LINE_W-1:0] buf_data_q, buf_data_d;
  logic [PTR_W-1:0]  head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]  count_q, count_d;
  entry_t            mem_q [QDEPTH];

  logic              line_hit, grp_taken, fetch_fire;
  logic [LINE_W-1:0] line_data;
  logic [ADDR_W-1:0] slot_pc;
  entry_t            slot_ent [FETCH_W];
  logic [PTR_W-1:0]  wr_ptr [FETCH_W];
  logic [PTR_W-1:0]  rd_ptr;
  int                word_idx, avail, grp_n, q_free, word_sel, enq_n, deq_n, out_k;

  // Fetch group: slice the line at the PC word index, cut after the first predicted-taken slot.
  // NOTE: every always_comb variable gets a default first so no path can infer a latch.
  always_comb begin
    line_hit  = buf_valid_q && (buf_tag_q == pc_q[ADDR_W-1:OFF_W]);
    ic_req    = !flush && !ic_stall && !line_hit;
    line_data = line_hit ? buf_data_q : ic_rdata_line;
    word_idx  = int'(pc_q[OFF_W-1:0]) >> 2;
    avail     = (LINE_WORDS - word_idx < FETCH_W) ? (LINE_WORDS - word_idx) : FETCH_W;
    grp_n     = 0;
    grp_taken = 1'b0;
    word_sel  = 0;
    slot_pc   = '0;
    for (int s = 0; s < FETCH_W; s++) begin
      word_sel           = (word_idx + s) % LINE_WORDS;
      slot_pc            = pc_q + ADDR_W'(4*s);
      wr_ptr[s]          = tail_q + PTR_W'(s);
      slot_ent[s].pc     = slot_pc;
      slot_ent[s].inst   = line_data[word_sel*INST_W +: INST_W];
      slot_ent[s].taken  = 1'b0;
      slot_ent[s].target = slot_pc + ADDR_W'(4);
      slot_ent[s].hist   = bp_hist;
      if (!grp_taken && s < avail) begin
        grp_n = s + 1;
        if (bp_taken_mask[s]) begin
          grp_taken          = 1'b1;
          slot_ent[s].taken  = 1'b1;
          slot_ent[s].target = bp_target;
        end
      end
    end
    // Free space is judged on the start-of-cycle count; same-cycle pops are not credited.
    q_free     = QDEPTH - int'(count_q);
    fetch_fire = !flush && !ic_stall && (line_hit || ic_valid) && (q_free >= grp_n);
  end

  always_comb begin
    out_k = (int'(count_q) < FETCH_W) ? int'(count_q) : FETCH_W;
    enq_n = fetch_fire ? grp_n : 0;
    deq_n = (deq.out_ready && !flush) ? out_k : 0;

    pc_d        = pc_q;
    buf_valid_d = buf_valid_q;
    buf_tag_d   = buf_tag_q;
    buf_data_d  = buf_data_q;
    if (ic_req && ic_valid) begin
      buf_valid_d = 1'b1;
      buf_tag_d   = pc_q[ADDR_W-1:OFF_W];
      buf_data_d  = ic_rdata_line;
    end
    if (fetch_fire) pc_d = grp_taken ? bp_target : pc_q + ADDR_W'(4*grp_n);
    tail_d  = tail_q + PTR_W'(enq_n);
    head_d  = head_q + PTR_W'(deq_n);
    count_d = CNT_W'(int'(count_q) + enq_n - deq_n);

    if (flush) begin
      pc_d        = redirect_pc;
      buf_valid_d = 1'b0;
      head_d      = '0;
      tail_d      = '0;
      count_d     = '0;
    end
  end

  // NOTE: state flops use non-blocking assignment and the asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= RESET_PC;
      buf_valid_q <= 1'b0;
      buf_tag_q   <= '0;
      buf_data_q  <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
    end else begin
      pc_q        <= pc_d;
      buf_valid_q <= buf_valid_d;
      buf_tag_q   <= buf_tag_d;
      buf_data_q  <= buf_data_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
    end
  end

  // NOTE: queue storage is deliberately not reset; the head/tail/count state alone qualifies it.
  always_ff @(posedge clk) begin
    for (int s = 0; s < FETCH_W; s++) begin
      if (fetch_fire && s < grp_n) mem_q[wr_ptr[s]] <= slot_ent[s];
    end
  end

  // Head entries are read straight from storage; unpresented slots are driven to zero.
  always_comb begin
    deq.out_valid       = '0;
    deq.out_pc          = '0;
    deq.out_inst        = '0;
    deq.out_pred_taken  = '0;
    deq.out_pred_target = '0;
    deq.out_pred_hist   = '0;
    rd_ptr              = '0;
    for (int s = 0; s < FETCH_W; s++) begin
      rd_ptr = head_q + PTR_W'(s);
      if (s < out_k) begin
        deq.out_valid[s]                        = 1'b1;
        deq.out_pc[s*ADDR_W +: ADDR_W]          = mem_q[rd_ptr].pc;
        deq.out_inst[s*INST_W +: INST_W]        = mem_q[rd_ptr].inst;
        deq.out_pred_taken[s]                   = mem_q[rd_ptr].taken;
        deq.out_pred_target[s*ADDR_W +: ADDR_W] = mem_q[rd_ptr].target;
        deq.out_pred_hist[s*HIST_W +: HIST_W]   = mem_q[rd_ptr].hist;
      end
    end
  end

  assign ic_paddr       = pc_q;
  assign bp_query_valid = fetch_fire;
  assign bp_query_pc    = pc_q;
  assign q_count        = count_q;
endmodule
